rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the write-data width.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register address width; NUM_REGS = 2**ADDR_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 stall  input  1  SHALL be the pipeline freeze; when high, no request is accepted.
REQ-006 req0_valid / req1_valid  input  1 each  SHALL flag a pending write from requester 0 (ALU writeback) / requester 1 (load writeback).
REQ-007 req0_addr / req1_addr  input  ADDR_WIDTH each  SHALL be the destination register index.
REQ-008 req0_data / req1_data  input  DATA_WIDTH each  SHALL be the write data.
REQ-009 req0_ready / req1_ready  output  1 each  SHALL be the combinational grant; transfer occurs when valid and ready are both high.
REQ-010 rf_en  output  NUM_REGS  SHALL be the one-hot per-register write enable driving the register file's en inputs.
REQ-011 rf_wd  output  DATA_WIDTH  SHALL be the shared write data driving the register file's D inputs.
REQ-012 rf_waddr  output  ADDR_WIDTH  SHALL be the index of the register being written, for debug and bypass.

Function
REQ-013 At most one request SHALL be accepted per cycle; ready is never high on both ports in the same cycle.
REQ-014 With stall low and exactly one valid, that requester SHALL get ready high in the same cycle.
REQ-015 With both valid and stall low, the grant SHALL be round-robin: the requester not granted most recently wins.
REQ-016 The FSM SHALL have three states: IDLE (no write last cycle), WR0 (req0 accepted last cycle), and WR1 (req1 accepted last cycle).
REQ-017 On a req0 transfer the next state SHALL be WR0; on a req1 transfer WR1; with no transfer, IDLE.
REQ-018 The round-robin pointer SHALL be held separately and SHALL be updated only on a transfer, so it survives IDLE cycles; its reset value favours req0.
REQ-019 Latency SHALL be one cycle: a transfer in cycle N produces rf_en, rf_wd and rf_waddr in cycle N+1.
REQ-020 rf_en SHALL be high for exactly one cycle per accepted request and all-zero otherwise.
REQ-021 A transfer with addr == 0 SHALL be accepted but SHALL leave rf_en all-zero; x0 is never written.
REQ-022 Stall asserted in the cycle after a transfer SHALL NOT cancel the registered write already in flight.
REQ-023 Back-to-back transfers SHALL be supported; the sustained throughput is one write per cycle.

Reset
REQ-024 While rst is low, the FSM SHALL be IDLE and the round-robin pointer SHALL be reset to favour req0.
REQ-025 While rst is low, rf_en, rf_wd and rf_waddr SHALL be 0, and both ready outputs SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight write immediately, with no enable pulse emitted.
REQ-027 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-028 With macro RF_WR_BYPASS_EN defined, the block SHALL add the following ports:
- rd_addr_a and rd_addr_b: inputs, ADDR_WIDTH each.
- byp_hit_a and byp_hit_b: outputs, 1 each.
- byp_data: output, DATA_WIDTH.
REQ-029 With RF_WR_BYPASS_EN defined, byp_hit_x SHALL be high when rf_en is nonzero and rd_addr_x equals rf_waddr; byp_data SHALL equal rf_wd.
REQ-030 With RF_WR_BYPASS_EN defined, rd_addr_x == 0 SHALL never produce a hit.
REQ-031 Without RF_WR_BYPASS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE/WR0/WR1) and the default DATA_WIDTH/ADDR_WIDTH constants.
REQ-033 The address decoder SHALL be one sub-module, rf_addr_decoder, which converts ADDR_WIDTH to one-hot NUM_REGS with a gating enable.

Verification
REQ-034 Single request: release reset, drive req0_valid=1, addr=5, data=0xDEADBEEF for one cycle. Required: req0_ready=1; next cycle rf_en=0x00000020 and rf_wd=0xDEADBEEF; the cycle after, rf_en=0.
REQ-035 Contention: hold both valid for 4 cycles from reset (addr0=1, addr1=2). Required: grants alternate req0, req1, req0, req1; rf_en sequence is 0x2, 0x4, 0x2, 0x4.
REQ-036 x0 suppression: drive req1_valid=1, addr=0, data=0x1234. Required: req1_ready=1 and rf_en stays 0 in the next cycle.
REQ-037 Stall: assert stall=1 with req0_valid=1 for 3 cycles, then release. Required: req0_ready=0 during the stall; exactly one write follows in the cycle after release.
REQ-038 Reset mid-flight: after a req0 transfer to addr 7, pull rst low before the next edge. Required: rf_en=0 immediately, and no write to register 7 occurs.
REQ-039 Bypass (with RF_WR_BYPASS_EN): transfer to addr 9 with data 0xA5A5A5A5, and set rd_addr_a=9, rd_addr_b=3 in the next cycle. Required: byp_hit_a=1, byp_hit_b=0, byp_data=0xA5A5A5A5.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: FSM state encoding,
// round-robin priority encoding and default datapath widths.
package rf_write_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    // State records which requester (if any) was accepted in the previous cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR0  = 2'b01,
        ST_WR1  = 2'b10
    } wr_state_e;

    // Which requester wins the next contended cycle.
    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } rr_prio_e;

    function automatic wr_state_e next_state(input logic grant0, input logic grant1);
        if (grant0) begin
            return ST_WR0;
        end else if (grant1) begin
            return ST_WR1;
        end
        return ST_IDLE;
    endfunction

endpackage : rf_write_arbiter_pkg

// File: rtl/rf_write_arbiter_addr_decoder.sv
// Binary register index to one-hot per-register write enable, gated by en.
module rf_addr_decoder #(
    parameter  int ADDR_WIDTH = 5,
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_REGS-1:0]   onehot
);

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule : rf_addr_decoder

// File: rtl/rf_write_arbiter.sv
// Two-port round-robin write arbiter in front of the register file, one-cycle
// write latency. Optional read-bypass ports are enabled with RF_WR_BYPASS_EN.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,

    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,

    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,

    output logic [NUM_REGS-1:0]   rf_en,
    output logic [DATA_WIDTH-1:0] rf_wd,
    output logic [ADDR_WIDTH-1:0] rf_waddr
`ifdef RF_WR_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  byp_hit_a,
    output logic                  byp_hit_b,
    output logic [DATA_WIDTH-1:0] byp_data
`endif
);

    wr_state_e             state_q, state_d;
    rr_prio_e              rr_q, rr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;

    logic grant0;
    logic grant1;
    logic write_en;

    // Grants are suppressed while reset is held so ready reads 0 during reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && !stall) begin
            if (req0_valid && req1_valid) begin
                grant0 = (rr_q == PRIO_REQ0);
                grant1 = (rr_q == PRIO_REQ1);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // The pointer moves only on a transfer, so it survives idle cycles.
    always_comb begin
        state_d = next_state(grant0, grant1);
        rr_d    = rr_q;
        waddr_d = '0;
        wd_d    = '0;
        if (grant0) begin
            rr_d    = PRIO_REQ1;
            waddr_d = req0_addr;
            wd_d    = req0_data;
        end else if (grant1) begin
            rr_d    = PRIO_REQ0;
            waddr_d = req1_addr;
            wd_d    = req1_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rr_q    <= PRIO_REQ0;
            waddr_q <= '0;
            wd_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            rr_q    <= rr_d;
            waddr_q <= waddr_d;
            wd_q    <= wd_d;
        end
    end

    // Register x0 is hard-wired: an accepted write to it never raises an enable.
    assign write_en = (state_q != ST_IDLE) && (waddr_q != '0);

    rf_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_decoder (
        .en     (write_en),
        .addr   (waddr_q),
        .onehot (rf_en)
    );

    assign rf_wd    = wd_q;
    assign rf_waddr = waddr_q;

`ifdef RF_WR_BYPASS_EN
    assign byp_hit_a = write_en && (rd_addr_a != '0) && (rd_addr_a == waddr_q);
    assign byp_hit_b = write_en && (rd_addr_b != '0) && (rd_addr_b == waddr_q);
    assign byp_data  = wd_q;
`endif

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter; bypass checks run when
// RF_WR_BYPASS_EN is defined.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic [NR-1:0] rf_en;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] rf_waddr;
`ifdef RF_WR_BYPASS_EN
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic          byp_hit_a, byp_hit_b;
    logic [DW-1:0] byp_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_en      (rf_en),
        .rf_wd      (rf_wd),
        .rf_waddr   (rf_waddr)
`ifdef RF_WR_BYPASS_EN
        ,
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .byp_hit_a  (byp_hit_a),
        .byp_hit_b  (byp_hit_b),
        .byp_data   (byp_data)
`endif
    );

    task automatic idle_inputs();
        stall      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_data  = '0;
        req1_data  = '0;
`ifdef RF_WR_BYPASS_EN
        rd_addr_a  = '0;
        rd_addr_b  = '0;
`endif
    endtask

    // Leaves rst high right after a falling edge, so the next rising edge is the
    // first one after release.
    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr  = 5'd4;
        req1_addr  = 5'd6;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (rf_en !== '0 || rf_wd !== '0 || rf_waddr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rf_en=%h rf_wd=%h rf_waddr=%0d expected all 0",
                     rf_en, rf_wd, rf_waddr);
        end
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        req0_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++;
        if (rf_en !== 32'h0000_0020 || rf_wd !== 32'hDEADBEEF || rf_waddr !== 5'd5) begin
            errors++;
            $display("FAIL single_write: rf_en=%h rf_wd=%h rf_waddr=%0d expected 00000020 deadbeef 5",
                     rf_en, rf_wd, rf_waddr);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_en !== '0) begin
            errors++;
            $display("FAIL single_pulse_end: rf_en=%h expected 0", rf_en);
        end
    endtask

    task automatic test_contention();
        logic [1:0]    exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [NR-1:0] exp_en  [4] = '{32'h2, 32'h4, 32'h2, 32'h4};
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr  = 5'd1;
        req1_addr  = 5'd2;
        req0_data  = 32'h1111_0000;
        req1_data  = 32'h2222_0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== exp_rdy[i]) begin
                errors++;
                $display("FAIL contention_ready[%0d]: got %b expected %b",
                         i, {req0_ready, req1_ready}, exp_rdy[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (rf_en !== exp_en[i]) begin
                errors++;
                $display("FAIL contention_en[%0d]: got %h expected %h", i, rf_en, exp_en[i]);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // req0 wins alone, two idle cycles follow, then contention must go to req1.
    task automatic test_rr_memory();
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 5'd10;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr  = 5'd11;
        req1_addr  = 5'd12;
        req1_data  = 32'hCAFE_0012;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rr_memory_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (rf_en !== 32'h0000_1000 || rf_wd !== 32'hCAFE_0012) begin
            errors++;
            $display("FAIL rr_memory_write: rf_en=%h rf_wd=%h expected 00001000 cafe0012",
                     rf_en, rf_wd);
        end
    endtask

    task automatic test_x0();
        do_reset();
        req1_valid = 1'b1;
        req1_addr  = 5'd0;
        req1_data  = 32'h0000_1234;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL x0_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        checks++;
        if (rf_en !== '0) begin
            errors++;
            $display("FAIL x0_suppress: rf_en=%h expected 0", rf_en);
        end
    endtask

    task automatic test_stall();
        do_reset();
        stall      = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 5'd3;
        req0_data  = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b expected 0", i, req0_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (rf_en !== '0) begin
                errors++;
                $display("FAIL stall_no_write[%0d]: rf_en=%h expected 0", i, rf_en);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b expected 1", req0_ready);
        end
        @(posedge clk); #1;
        // Stall rising right after the transfer must not cancel the pending write.
        req0_valid = 1'b0;
        stall      = 1'b1;
        #1;
        checks++;
        if (rf_en !== 32'h0000_0008 || rf_wd !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL stall_release_write: rf_en=%h rf_wd=%h expected 00000008 0badf00d",
                     rf_en, rf_wd);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_en !== '0) begin
            errors++;
            $display("FAIL stall_single_write: rf_en=%h expected 0", rf_en);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3] = '{5'd17, 5'd18, 5'd31};
        do_reset();
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_addr = addrs[i];
            req0_data = 32'h5000_0000 + 32'(i);
            @(posedge clk); #1;
            checks++;
            if (rf_en !== (32'h1 << addrs[i]) || rf_wd !== 32'h5000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: rf_en=%h rf_wd=%h expected %h %h",
                         i, rf_en, rf_wd, 32'h1 << addrs[i], 32'h5000_0000 + 32'(i));
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        // Reset before the accepting edge: the write never appears.
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 5'd7;
        req0_data  = 32'h7777_7777;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || rf_en !== '0) begin
            errors++;
            $display("FAIL midflight_pre_edge: ready=%b rf_en=%h expected 0 0", req0_ready, rf_en);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_en !== '0 || rf_waddr !== '0) begin
            errors++;
            $display("FAIL midflight_no_write: rf_en=%h rf_waddr=%0d expected 0 0", rf_en, rf_waddr);
        end
        // Reset while the enable is already up: it must drop immediately.
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 5'd7;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst        = 1'b0;
        #1;
        checks++;
        if (rf_en !== '0 || rf_wd !== '0) begin
            errors++;
            $display("FAIL midflight_async_clear: rf_en=%h rf_wd=%h expected 0 0", rf_en, rf_wd);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rf_en !== '0) begin
            errors++;
            $display("FAIL midflight_after_release: rf_en=%h expected 0", rf_en);
        end
    endtask

`ifdef RF_WR_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 5'd9;
        req0_data  = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rd_addr_a  = 5'd9;
        rd_addr_b  = 5'd3;
        #1;
        checks++;
        if (byp_hit_a !== 1'b1 || byp_hit_b !== 1'b0 || byp_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_hit: hit_a=%b hit_b=%b data=%h expected 1 0 a5a5a5a5",
                     byp_hit_a, byp_hit_b, byp_data);
        end
        @(negedge clk);
        req1_valid = 1'b1;
        req1_addr  = 5'd0;
        rd_addr_a  = 5'd0;
        rd_addr_b  = 5'd0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        #1;
        checks++;
        if (byp_hit_a !== 1'b0 || byp_hit_b !== 1'b0) begin
            errors++;
            $display("FAIL bypass_x0: hit_a=%b hit_b=%b expected 0 0", byp_hit_a, byp_hit_b);
        end
        @(posedge clk); #1;
        rd_addr_a = 5'd9;
        #1;
        checks++;
        if (byp_hit_a !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle: hit_a=%b expected 0", byp_hit_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_rr_memory();
        test_x0();
        test_stall();
        test_back_to_back();
        test_reset_midflight();
`ifdef RF_WR_BYPASS_EN
        test_bypass();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule : tb_rf_write_arbiter
